// File: rtl/nodo_frontera_param.sv
// Frontier node of a mesh ring: buffers whole packets, rewrites unwitnessed headers
// toward the next ring position, and forwards them under credit-based flow control.
module nodo_frontera_param #(
    parameter int CHANNEL_WIDTH  = 32,
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_FLITS     = 4,
    parameter int BUFFER_PKTS    = 2,
    parameter int X_WIDTH        = 2,
    parameter int Y_WIDTH        = 2,
    parameter int X_LOCAL        = 0,
    parameter int Y_LOCAL        = 1,
    parameter int DROP_WITNESSED = 0,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNEL_WIDTH-1:0] channel_din,
    output logic                     credit_out_dout,
    output logic [CHANNEL_WIDTH-1:0] channel_dout,
    input  logic                     credit_in_din,
    output logic [CNT_WIDTH-1:0]     bounced_count_dout,
    output logic [CNT_WIDTH-1:0]     dropped_count_dout,
    output logic                     overflow_dout
);

    localparam int CW        = CHANNEL_WIDTH;
    localparam int AW        = ADDR_WIDTH;
    localparam int PKT_FLITS = DATA_FLITS + 1;
    localparam int DEPTH     = BUFFER_PKTS * PKT_FLITS;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PC_W      = $clog2(BUFFER_PKTS + 1);
    localparam int DC_W      = (DATA_FLITS > 1) ? $clog2(DATA_FLITS) : 1;
    localparam int TC_W      = $clog2(PKT_FLITS);

    // Next hop on the frontier ring, resolved from which edge this node sits on.
    localparam bit ON_TOP    = (Y_LOCAL == Y_WIDTH + 1);
    localparam bit ON_BOTTOM = (Y_LOCAL == 0);
    localparam bit ON_RIGHT  = (X_LOCAL == X_WIDTH + 1);
    localparam int RING_X    = (X_LOCAL == X_WIDTH) ? X_LOCAL : X_LOCAL + 1;
    localparam int RING_Y    = (Y_LOCAL == Y_WIDTH) ? 1 : Y_LOCAL + 1;
    localparam int NEW_X     = (ON_TOP || ON_BOTTOM) ? RING_X
                             : (ON_RIGHT ? X_LOCAL : X_WIDTH + 1);
    localparam int NEW_Y     = ON_TOP ? 0 : (ON_BOTTOM ? Y_WIDTH + 1 : RING_Y);
    localparam logic [AW-1:0] NEW_X_A = AW'(NEW_X);
    localparam logic [AW-1:0] NEW_Y_A = AW'(NEW_Y);

    localparam logic [DC_W-1:0]  RX_LAST  = DC_W'(DATA_FLITS - 1);
    localparam logic [TC_W-1:0]  TX_LAST  = TC_W'(PKT_FLITS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [PC_W-1:0]  PKTS_MAX = PC_W'(BUFFER_PKTS);

    typedef enum logic {RX_IDLE, RX_ACTIVE} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    typedef struct packed {
        rx_state_e       state;
        logic [DC_W-1:0] cnt;
        logic            accept;
    } rx_t;

    typedef struct packed {
        tx_state_e       state;
        logic [TC_W-1:0] cnt;
    } tx_t;

    rx_t rx_q, rx_d;
    tx_t tx_q, tx_d;

    logic [CW-1:0]        fifo_mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PC_W-1:0]      pkts_q, pkts_d;
    logic [PC_W-1:0]      slots_q, slots_d;
    logic [PC_W-1:0]      credits_q, credits_d;
    logic [1:0]           pend_q, pend_d;
    logic [CW-1:0]        dout_q, dout_d;
    logic                 cred_out_q, cred_out_d;
    logic [CNT_WIDTH-1:0] bounced_q, bounced_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
    logic                 ovf_q, ovf_d;

    logic [CW-1:0] hdr_rw;
    logic [CW-1:0] wr_data;
    logic          wr_en;
    logic          accept_hdr;
    logic          drop_hdr;
    logic          drop_ovf;
    logic          bounce;
    logic          rx_done;
    logic          drop_done;
    logic          start_ok;
    logic          tx_start;
    logic          tx_last;
    logic          rd_en;

    always_comb begin
        hdr_rw                  = channel_din;
        hdr_rw[CW-2]            = 1'b1;
        hdr_rw[CW-3 -: AW]      = NEW_X_A;
        hdr_rw[CW-3-AW -: AW]   = NEW_Y_A;
    end

    // Receive side: the packet's fate is decided on its header cycle and carried
    // through the data flits, which are taken blindly on consecutive cycles.
    always_comb begin
        rx_d       = rx_q;
        wr_en      = 1'b0;
        wr_data    = channel_din;
        accept_hdr = 1'b0;
        drop_hdr   = 1'b0;
        drop_ovf   = 1'b0;
        bounce     = 1'b0;
        rx_done    = 1'b0;
        drop_done  = 1'b0;
        case (rx_q.state)
            RX_IDLE: begin
                if (channel_din[CW-1]) begin
                    rx_d.state = RX_ACTIVE;
                    rx_d.cnt   = '0;
                    if (slots_q == PKTS_MAX) begin
                        rx_d.accept = 1'b0;
                        drop_hdr    = 1'b1;
                        drop_ovf    = 1'b1;
                    end else if ((DROP_WITNESSED != 0) && channel_din[CW-2]) begin
                        rx_d.accept = 1'b0;
                        drop_hdr    = 1'b1;
                    end else begin
                        rx_d.accept = 1'b1;
                        accept_hdr  = 1'b1;
                        wr_en       = 1'b1;
                        if (!channel_din[CW-2]) begin
                            bounce  = 1'b1;
                            wr_data = hdr_rw;
                        end
                    end
                end
            end
            RX_ACTIVE: begin
                wr_en = rx_q.accept;
                if (rx_q.cnt == RX_LAST) begin
                    rx_d.state = RX_IDLE;
                    rx_done    = rx_q.accept;
                    drop_done  = !rx_q.accept;
                end else begin
                    rx_d.cnt = rx_q.cnt + DC_W'(1);
                end
            end
            default: rx_d.state = RX_IDLE;
        endcase
    end

    // Transmit side: a new packet may start on the cycle the previous one sends
    // its last flit, so packets leave back-to-back when credit allows.
    always_comb begin
        tx_d     = tx_q;
        start_ok = (pkts_q != '0) && (credits_q != '0);
        tx_start = 1'b0;
        tx_last  = 1'b0;
        rd_en    = 1'b0;
        dout_d   = '0;
        case (tx_q.state)
            TX_IDLE: begin
                if (start_ok) begin
                    tx_start   = 1'b1;
                    tx_d.state = TX_SEND;
                    tx_d.cnt   = '0;
                end
            end
            TX_SEND: begin
                rd_en  = 1'b1;
                dout_d = fifo_mem[rd_ptr_q];
                if (tx_q.cnt == TX_LAST) begin
                    tx_last = 1'b1;
                    if (start_ok) begin
                        tx_start = 1'b1;
                        tx_d.cnt = '0;
                    end else begin
                        tx_d.state = TX_IDLE;
                    end
                end else begin
                    tx_d.cnt = tx_q.cnt + TC_W'(1);
                end
            end
            default: tx_d.state = TX_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        rd_ptr_d = rd_ptr_q;
        if (rd_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        pkts_d = pkts_q;
        if (rx_done && !tx_start) begin
            pkts_d = pkts_q + PC_W'(1);
        end else if (!rx_done && tx_start) begin
            pkts_d = pkts_q - PC_W'(1);
        end

        // A slot stays owned from header acceptance until its last flit leaves.
        slots_d = slots_q;
        if (accept_hdr && !tx_last) begin
            slots_d = slots_q + PC_W'(1);
        end else if (!accept_hdr && tx_last) begin
            slots_d = slots_q - PC_W'(1);
        end

        credits_d = credits_q;
        if (tx_start && !credit_in_din) begin
            credits_d = credits_q - PC_W'(1);
        end else if (!tx_start && credit_in_din && (credits_q != PKTS_MAX)) begin
            credits_d = credits_q + PC_W'(1);
        end

        // Drop credits yield to the forwarded-packet credit and are replayed later.
        cred_out_d = 1'b0;
        pend_d     = pend_q;
        if (tx_last) begin
            cred_out_d = 1'b1;
            if (drop_done) begin
                pend_d = pend_q + 2'd1;
            end
        end else if (drop_done) begin
            cred_out_d = 1'b1;
        end else if (pend_q != 2'd0) begin
            cred_out_d = 1'b1;
            pend_d     = pend_q - 2'd1;
        end

        bounced_d = bounced_q;
        if (bounce && !(&bounced_q)) begin
            bounced_d = bounced_q + CNT_WIDTH'(1);
        end
        dropped_d = dropped_q;
        if (drop_hdr && !(&dropped_q)) begin
            dropped_d = dropped_q + CNT_WIDTH'(1);
        end
        ovf_d = ovf_q | drop_ovf;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_q.state <= RX_IDLE;
            rx_q.cnt   <= '0;
            rx_q.accept <= 1'b0;
            tx_q.state <= TX_IDLE;
            tx_q.cnt   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkts_q     <= '0;
            slots_q    <= '0;
            credits_q  <= PKTS_MAX;
            pend_q     <= 2'd0;
            dout_q     <= '0;
            cred_out_q <= 1'b0;
            bounced_q  <= '0;
            dropped_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkts_q     <= pkts_d;
            slots_q    <= slots_d;
            credits_q  <= credits_d;
            pend_q     <= pend_d;
            dout_q     <= dout_d;
            cred_out_q <= cred_out_d;
            bounced_q  <= bounced_d;
            dropped_q  <= dropped_d;
            ovf_q      <= ovf_d;
        end
    end

    assign channel_dout       = dout_q;
    assign credit_out_dout    = cred_out_q;
    assign bounced_count_dout = bounced_q;
    assign dropped_count_dout = dropped_q;
    assign overflow_dout      = ovf_q;

endmodule

// File: tb/tb_nodo_frontera_param.sv
// Randomized scoreboard bench for nodo_frontera_param with a packet-level reference model.
module tb_nodo_frontera_param;

    localparam int CW  = 32;
    localparam int PKT = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] din = '0;
    logic [CW-1:0] din2 = '0;
    logic          cin = 1'b0;
    logic          cin2 = 1'b0;

    logic          cout_m, cout_w, cout_t, cout_b, cout_r;
    logic [CW-1:0] dout_m, dout_w, dout_t, dout_b, dout_r;
    logic [15:0]   bc_m, bc_w, bc_t, bc_b, bc_r;
    logic [15:0]   dc_m, dc_w, dc_t, dc_b, dc_r;
    logic          ov_m, ov_w, ov_t, ov_b, ov_r;

    nodo_frontera_param u_main (
        .clk(clk), .reset(reset), .channel_din(din), .credit_out_dout(cout_m),
        .channel_dout(dout_m), .credit_in_din(cin), .bounced_count_dout(bc_m),
        .dropped_count_dout(dc_m), .overflow_dout(ov_m));

    nodo_frontera_param #(.DROP_WITNESSED(1)) u_wit (
        .clk(clk), .reset(reset), .channel_din(din2), .credit_out_dout(cout_w),
        .channel_dout(dout_w), .credit_in_din(cin2), .bounced_count_dout(bc_w),
        .dropped_count_dout(dc_w), .overflow_dout(ov_w));

    nodo_frontera_param #(.X_LOCAL(2), .Y_LOCAL(3)) u_top (
        .clk(clk), .reset(reset), .channel_din(din2), .credit_out_dout(cout_t),
        .channel_dout(dout_t), .credit_in_din(cin2), .bounced_count_dout(bc_t),
        .dropped_count_dout(dc_t), .overflow_dout(ov_t));

    nodo_frontera_param #(.X_LOCAL(2), .Y_LOCAL(0)) u_bot (
        .clk(clk), .reset(reset), .channel_din(din2), .credit_out_dout(cout_b),
        .channel_dout(dout_b), .credit_in_din(cin2), .bounced_count_dout(bc_b),
        .dropped_count_dout(dc_b), .overflow_dout(ov_b));

    nodo_frontera_param #(.X_LOCAL(3), .Y_LOCAL(2)) u_right (
        .clk(clk), .reset(reset), .channel_din(din2), .credit_out_dout(cout_r),
        .channel_dout(dout_r), .credit_in_din(cin2), .bounced_count_dout(bc_r),
        .dropped_count_dout(dc_r), .overflow_dout(ov_r));

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_q[$];
    bit            in_pkt = 0;
    int            idx = 0;
    int            cred_seen = 0;
    int            cred_exp = 0;
    int            bounce_exp = 0;
    int            main_nx, main_ny;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, got, exp);
        end
    endtask

    // Ring successor from the edge rules.
    function automatic void new_coords(input int xl, input int yl, input int xw, input int yw,
                                       output int nx, output int ny);
        if (yl == yw + 1 || yl == 0) begin
            nx = (xl == xw) ? xl : xl + 1;
            ny = (yl == 0) ? yw + 1 : 0;
        end else begin
            nx = (xl == xw + 1) ? xl : xw + 1;
            ny = (yl == yw) ? 1 : yl + 1;
        end
    endfunction

    function automatic logic [CW-1:0] model_hdr(input logic [CW-1:0] h, input int nx, input int ny);
        logic [CW-1:0] m;
        if (h[30]) return h;
        m = (h & ~32'h7F00_0000) | 32'h4000_0000;
        m = m | (CW'(nx & 7) << 27) | (CW'(ny & 7) << 24);
        return m;
    endfunction

    // Monitor: pops one expected flit per outbound flit of the main node.
    initial begin
        logic [CW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                in_pkt = 0;
                idx = 0;
            end else begin
                if (cout_m) cred_seen++;
                if (in_pkt || dout_m[CW-1]) begin
                    in_pkt = 1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_flit actual=%0h required=none", dout_m);
                        in_pkt = 0;
                    end else begin
                        e = exp_q.pop_front();
                        check("flit", dout_m, e);
                        if (idx == PKT - 1) begin
                            check("credit_on_last", cout_m, 1);
                            in_pkt = 0;
                            idx = 0;
                        end else begin
                            idx++;
                        end
                    end
                end else if (dout_m != '0) begin
                    checks++;
                    errors++;
                    $display("FAIL idle_nonzero actual=%0h required=0", dout_m);
                end
            end
        end
    end

    task automatic send_pkt(input logic [CW-1:0] hdr, input bit fwd);
        logic [CW-1:0] d;
        if (fwd) begin
            exp_q.push_back(model_hdr(hdr, main_nx, main_ny));
            if (!hdr[30]) bounce_exp++;
        end
        cred_exp++;
        @(negedge clk) din = hdr;
        for (int i = 0; i < PKT - 1; i++) begin
            d = $urandom;
            if (fwd) exp_q.push_back(d);
            @(negedge clk) din = d;
        end
    endtask

    task automatic idle_din();
        @(negedge clk) din = '0;
    endtask

    task automatic pulse_credit();
        @(negedge clk) cin = 1'b1;
        @(negedge clk) cin = 1'b0;
    endtask

    task automatic wait_drain(input int max, input string name);
        for (int i = 0; i < max && (exp_q.size() != 0 || in_pkt); i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic send2(input logic [CW-1:0] hdr);
        @(negedge clk) din2 = hdr;
        for (int i = 0; i < PKT - 1; i++) @(negedge clk) din2 = $urandom;
        @(negedge clk) din2 = '0;
    endtask

    logic [CW-1:0] cap_w, cap_t, cap_b, cap_r;
    bit            got_w, got_t, got_b, got_r;
    int            wit_nonzero, wit_cred;

    task automatic capture2(input int cycles);
        got_w = 0; got_t = 0; got_b = 0; got_r = 0;
        cap_w = '0; cap_t = '0; cap_b = '0; cap_r = '0;
        wit_nonzero = 0; wit_cred = 0;
        for (int i = 0; i < cycles; i++) begin
            if (!got_w && dout_w[CW-1]) begin cap_w = dout_w; got_w = 1; end
            if (!got_t && dout_t[CW-1]) begin cap_t = dout_t; got_t = 1; end
            if (!got_b && dout_b[CW-1]) begin cap_b = dout_b; got_b = 1; end
            if (!got_r && dout_r[CW-1]) begin cap_r = dout_r; got_r = 1; end
            if (dout_w != '0) wit_nonzero++;
            if (cout_w) wit_cred++;
            @(negedge clk);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] hdr;
        int            n;
        new_coords(0, 1, 2, 2, main_nx, main_ny);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", dout_m, 0);
        check("rst_cout", cout_m, 0);
        check("rst_bounced", bc_m, 0);
        check("rst_dropped", dc_m, 0);
        check("rst_ovf", ov_m, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_dout", dout_m, 0);

        // Edge sweep and witnessed-drop nodes
        hdr = {1'b1, 1'b0, 3'd1, 3'd1, 24'($urandom)};
        send2(hdr);
        capture2(25);
        check("wit_seen", got_w, 1);
        check("top_seen", got_t, 1);
        check("bot_seen", got_b, 1);
        check("right_seen", got_r, 1);
        check("wit_hdr", cap_w, model_hdr(hdr, 3, 2));
        check("top_hdr", cap_t, model_hdr(hdr, 2, 0));
        check("bot_hdr", cap_b, model_hdr(hdr, 2, 3));
        check("right_hdr", cap_r, model_hdr(hdr, 3, 1));
        check("top_bounced", bc_t, 1);
        hdr = {1'b1, 1'b1, 30'($urandom)};
        send2(hdr);
        capture2(25);
        check("wit_drop_quiet", wit_nonzero, 0);
        check("wit_drop_credit", wit_cred, 1);
        check("wit_dropped", dc_w, 1);
        check("wit_ovf", ov_w, 0);
        check("wit_bounced", bc_w, 1);
        check("top_fwd_unchanged", cap_t, hdr);

        // Single bounced packet, then a witnessed one forwarded unchanged
        send_pkt({1'b1, 1'b0, 3'd1, 3'd1, 24'($urandom)}, 1);
        idle_din();
        wait_drain(40, "first_pkt");
        check("first_bounced", bc_m, 1);
        pulse_credit();
        send_pkt({1'b1, 1'b1, 30'($urandom)}, 1);
        idle_din();
        wait_drain(40, "witnessed_pkt");
        check("witnessed_bounced", bc_m, 1);
        pulse_credit();

        // Random traffic in groups of one or two packets
        for (int g = 0; g < 12; g++) begin
            n = $urandom_range(1, 2);
            for (int k = 0; k < n; k++) send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
            idle_din();
            repeat ($urandom_range(0, 5)) @(negedge clk);
            wait_drain(60, "rand_drain");
            for (int k = 0; k < n; k++) pulse_credit();
        end
        check("rand_bounced", bc_m, bounce_exp);
        check("rand_dropped", dc_m, 0);
        check("rand_ovf", ov_m, 0);
        check("rand_credits", cred_seen, cred_exp);

        // Three back-to-back packets with no credit returned: the third overflows
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 0);
        idle_din();
        wait_drain(60, "ovf_drain");
        repeat (5) @(negedge clk);
        check("ovf_flag", ov_m, 1);
        check("ovf_dropped", dc_m, 1);
        check("ovf_credits", cred_seen, cred_exp);
        pulse_credit();
        repeat (20) @(negedge clk);
        check("empty_after_credit", cred_seen, cred_exp);

        // Credit starvation and release
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        idle_din();
        wait_drain(40, "last_credit_pkt");
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        idle_din();
        repeat (25) @(negedge clk);
        check("held_no_credit", exp_q.size(), PKT);
        pulse_credit();
        wait_drain(30, "released_pkt");
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        idle_din();
        repeat (25) @(negedge clk);
        check("held_again", exp_q.size(), PKT);
        @(negedge clk) cin = 1'b1;
        @(negedge clk) cin = 1'b1;
        @(negedge clk) cin = 1'b0;
        wait_drain(30, "two_credit_release");
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        idle_din();
        wait_drain(40, "saved_credit_pkt");
        send_pkt({1'b1, 1'($urandom_range(0, 1)), 30'($urandom)}, 1);
        idle_din();
        repeat (25) @(negedge clk);
        check("held_third", exp_q.size(), PKT);
        pulse_credit();
        wait_drain(30, "third_release");
        check("starve_bounced", bc_m, bounce_exp);
        check("starve_credits", cred_seen, cred_exp);

        // Reset in the middle of an inbound packet
        @(negedge clk) din = {1'b1, 1'b0, 30'($urandom)};
        @(negedge clk) din = $urandom;
        @(negedge clk) din = $urandom;
        reset = 1'b1;
        #1;
        check("mid_rst_dout", dout_m, 0);
        check("mid_rst_cout", cout_m, 0);
        check("mid_rst_bounced", bc_m, 0);
        check("mid_rst_dropped", dc_m, 0);
        check("mid_rst_ovf", ov_m, 0);
        @(negedge clk) din = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        bounce_exp = 0;
        cred_exp = 0;
        cred_seen = 0;
        send_pkt({1'b1, 1'b0, 30'($urandom)}, 1);
        idle_din();
        wait_drain(40, "post_rst_pkt");
        check("post_rst_bounced", bc_m, 1);
        check("post_rst_dropped", dc_m, 0);
        check("post_rst_ovf", ov_m, 0);
        check("post_rst_credits", cred_seen, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
